// File: rtl/event_pkg.sv
// Shared definitions for the event distribution/join blocks.
package event_pkg;

    // Widest fork supported by the event system.
    localparam int EVT_MAX_OUT = 8;

    // Width of the optional saturating dropped-event counter.
    localparam int EVT_DROP_CNT_W = 8;

    // Largest value a pending counter of the given width can hold.
    function automatic int cnt_max(input int cnt_width);
        return (1 << cnt_width) - 1;
    endfunction

endpackage

// File: rtl/event_fork_chan.sv
// One output channel of the event fork: pending-event counter, ready gate
// and registered single-cycle output pulse.
module event_fork_chan
    import event_pkg::*;
#(
    parameter int CNT_WIDTH    = 4,
    parameter int INIT_PENDING = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic acc,
    input  logic ready,
    output logic pulse,
    output logic full
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(cnt_max(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(INIT_PENDING);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt;
    logic                 emit;

    // Emit when the consumer is ready and an event is pending or arriving now.
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every
        // path (here unconditionally) so no latch is inferred.
        emit = ready && ((cnt != '0) || acc);
        full = (cnt == CNT_MAX);
    end

    // Counter and pulse register; accept and emit in one cycle cancel out.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            cnt   <= CNT_INIT;
            pulse <= 1'b0;
        end else begin
            pulse <= emit;
            case ({acc, emit})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/event_fork.sv
// Event fork: re-issues each accepted input pulse once on every output
// channel, buffering per channel so slow consumers lose nothing.
// Optional build macro EVENT_FORK_DROP_CNT_EN adds a saturating drop_cnt
// output; the sticky overflow flag then follows drop_cnt != 0.
module event_fork
    import event_pkg::*;
#(
    parameter int NUM_OUT      = 2,
    parameter int CNT_WIDTH    = 4,
    parameter int INIT_PENDING = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_pulse,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [NUM_OUT-1:0] out_pulse,
    output logic               in_full,
    output logic               overflow
`ifdef EVENT_FORK_DROP_CNT_EN
    ,
    output logic [EVT_DROP_CNT_W-1:0] drop_cnt
`endif
);

    if (NUM_OUT < 2 || NUM_OUT > EVT_MAX_OUT) begin : g_bad_num_out
        $error("event_fork: NUM_OUT must be 2..%0d", EVT_MAX_OUT);
    end
    if (INIT_PENDING != 0 && INIT_PENDING != 1) begin : g_bad_init
        $error("event_fork: INIT_PENDING must be 0 or 1");
    end

    logic [NUM_OUT-1:0] chan_full;
    logic               acc;
    logic               drop;

    // All-or-nothing acceptance: any full channel blocks every channel, even
    // one that is emitting this cycle, so there is no ready-to-accept path.
    always_comb begin
        in_full = |chan_full;
        acc     = in_pulse && !in_full;
        drop    = in_pulse && in_full;
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_chan
        event_fork_chan #(
            .CNT_WIDTH   (CNT_WIDTH),
            .INIT_PENDING(INIT_PENDING)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .acc  (acc),
            .ready(out_ready[i]),
            .pulse(out_pulse[i]),
            .full (chan_full[i])
        );
    end

`ifdef EVENT_FORK_DROP_CNT_EN
    // Saturating count of dropped events; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + EVT_DROP_CNT_W'(1);
        end
    end

    assign overflow = (drop_cnt != '0);
`else
    // Sticky flag: set by the first dropped event, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_event_fork.sv
// Self-checking bench for event_fork (NUM_OUT=2, CNT_WIDTH=2, INIT_PENDING=1).
// The driver applies one directed vector per cycle at the falling edge and
// queues the hand-computed outputs expected after the next rising edge; the
// monitor pops and compares shortly after each rising edge.
module tb_event_fork;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_pulse = 1'b0;
    logic [1:0] out_ready = 2'b00;
    logic [1:0] out_pulse;
    logic       in_full;
    logic       overflow;
`ifdef EVENT_FORK_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    typedef struct {
        logic [1:0] pulse;
        logic       full;
        logic       ovf;
        logic [7:0] drops;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    event_fork #(
        .NUM_OUT     (2),
        .CNT_WIDTH   (2),
        .INIT_PENDING(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_pulse (in_pulse),
        .out_ready(out_ready),
        .out_pulse(out_pulse),
        .in_full  (in_full),
        .overflow (overflow)
`ifdef EVENT_FORK_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // One cycle of stimulus plus the outputs expected after the next edge.
    task automatic vec(input logic r, input logic i, input logic [1:0] rdy,
                       input logic [1:0] p, input logic f, input logic o,
                       input int d);
        exp_t e;
        @(negedge clk);
        rst       = r;
        in_pulse  = i;
        out_ready = rdy;
        e.pulse = p;
        e.full  = f;
        e.ovf   = o;
        e.drops = 8'(d);
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_pulse", {6'b0, out_pulse}, {6'b0, e.pulse});
                check("in_full", {7'b0, in_full}, {7'b0, e.full});
                check("overflow", {7'b0, overflow}, {7'b0, e.ovf});
`ifdef EVENT_FORK_DROP_CNT_EN
                check("drop_cnt", drop_cnt, e.drops);
`endif
            end
        end
    end

    initial begin
        int waited;
        // Reset held two cycles; counters primed to 1, no pulse yet.
        vec(1, 0, 2'b11, 2'b00, 0, 0, 0);
        vec(1, 0, 2'b11, 2'b00, 0, 0, 0);
        // Primed event emitted exactly once after reset falls.
        vec(0, 0, 2'b11, 2'b11, 0, 0, 0);
        vec(0, 0, 2'b11, 2'b00, 0, 0, 0);
        // Back-to-back input with both ready: pass-through, counters stay 0.
        vec(0, 1, 2'b11, 2'b11, 0, 0, 0);
        vec(0, 1, 2'b11, 2'b11, 0, 0, 0);
        vec(0, 1, 2'b11, 2'b11, 0, 0, 0);
        vec(0, 0, 2'b11, 2'b00, 0, 0, 0);
        // Channel 1 stalled: it accumulates up to max while channel 0 passes.
        vec(0, 1, 2'b01, 2'b01, 0, 0, 0);
        vec(0, 1, 2'b01, 2'b01, 0, 0, 0);
        vec(0, 1, 2'b01, 2'b01, 1, 0, 0);
        // Channel 1 released: drains one per cycle.
        vec(0, 0, 2'b11, 2'b10, 0, 0, 0);
        vec(0, 0, 2'b11, 2'b10, 0, 0, 0);
        vec(0, 0, 2'b11, 2'b10, 0, 0, 0);
        vec(0, 0, 2'b11, 2'b00, 0, 0, 0);
        // Build cnt=2, then accept and emit together: count unchanged.
        vec(0, 1, 2'b00, 2'b00, 0, 0, 0);
        vec(0, 1, 2'b00, 2'b00, 0, 0, 0);
        vec(0, 1, 2'b11, 2'b11, 0, 0, 0);
        // Fill to max, then drop.
        vec(0, 1, 2'b00, 2'b00, 1, 0, 0);
        vec(0, 1, 2'b00, 2'b00, 1, 1, 1);
        // Full channels emitting still refuse the input (conservative full).
        vec(0, 1, 2'b11, 2'b11, 0, 1, 2);
        vec(0, 0, 2'b11, 2'b11, 0, 1, 2);
        vec(0, 0, 2'b11, 2'b11, 0, 1, 2);
        vec(0, 0, 2'b11, 2'b00, 0, 1, 2);
        // Reset mid-burst with cnt=3: only the primed event survives.
        vec(0, 1, 2'b00, 2'b00, 0, 1, 2);
        vec(0, 1, 2'b00, 2'b00, 0, 1, 2);
        vec(0, 1, 2'b00, 2'b00, 1, 1, 2);
        vec(1, 1, 2'b11, 2'b00, 0, 0, 0);
        vec(0, 0, 2'b11, 2'b11, 0, 0, 0);
        vec(0, 0, 2'b11, 2'b00, 0, 0, 0);
        // Mixed readiness: 1-cycle pass on ch1, ch0 delivers a cycle later.
        vec(0, 1, 2'b10, 2'b10, 0, 0, 0);
        vec(0, 0, 2'b01, 2'b01, 0, 0, 0);
        vec(0, 0, 2'b11, 2'b00, 0, 0, 0);
`ifdef EVENT_FORK_DROP_CNT_EN
        // Saturating drop counter: fill, drop 300 events, then reset.
        vec(0, 1, 2'b00, 2'b00, 0, 0, 0);
        vec(0, 1, 2'b00, 2'b00, 0, 0, 0);
        vec(0, 1, 2'b00, 2'b00, 1, 0, 0);
        for (int k = 1; k <= 300; k++) begin
            vec(0, 1, 2'b00, 2'b00, 1, 1, (k > 255) ? 255 : k);
        end
        vec(1, 0, 2'b00, 2'b00, 0, 0, 0);
`endif
        // Let the monitor drain the queue, bounded.
        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #3;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
